// File: rtl/pdm_cic_decim_if.sv
// PCM output bus of pdm_cic_decim: signed word plus valid/ready handshake.
// The decimator drives the master side; the consumer uses the slave side.
interface pdm_cic_decim_if #(
    parameter int OUT_BITS = 16
);
    logic [OUT_BITS-1:0] pcm_data;
    logic                pcm_valid;
    logic                pcm_ready;

    modport master (output pcm_data, output pcm_valid, input pcm_ready);
    modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_cic_decim.sv
// Third-order CIC decimator (R = 2^LOG2_R) turning a 1-bit PDM stream into signed PCM words.
// Optional build macro PDM_CIC_SAT_EN clips the positive full-scale result instead of letting it wrap.
module pdm_cic_decim #(
    parameter int LOG2_R   = 6,
    parameter int OUT_BITS = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sample_valid,
    input  logic           data,
    input  logic           sync,
    pdm_cic_decim_if.master pcm,
    output logic           overrun
);
    localparam int W  = 3*LOG2_R + 2;
    localparam int SH = 3*LOG2_R + 1 - OUT_BITS;
    localparam logic [W-1:0] POS_FS = W'(1) << (3*LOG2_R);

    logic [LOG2_R-1:0]   phase_q, phase_d;
    logic                dec_go_q, dec_go_d;
    logic [W-1:0]        integ_q [0:2];
    logic [W-1:0]        integ_d [0:2];
    logic [W-1:0]        dly_q   [0:2];
    logic [W-1:0]        dly_d   [0:2];
    logic [W-1:0]        comb_s  [0:3];
    logic [OUT_BITS-1:0] pcm_data_q, pcm_data_d;
    logic                pcm_valid_q, pcm_valid_d;
    logic                overrun_q, overrun_d;
    logic [W-1:0]        step;
    logic [W-1:0]        acc;
    logic [W-1:0]        c_clip;
    logic [OUT_BITS-1:0] word;

    assign step      = data ? W'(1) : {W{1'b1}};
    assign comb_s[0] = integ_q[2];

    // Comb chain with differential delay 1; only meaningful in the dec_go cycle.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_comb
            assign comb_s[gi+1] = comb_s[gi] - dly_q[gi];
        end
    endgenerate

`ifdef PDM_CIC_SAT_EN
    assign c_clip = (comb_s[3] == POS_FS) ? (POS_FS - W'(1)) : comb_s[3];
`else
    assign c_clip = comb_s[3];
`endif

    assign word = OUT_BITS'($signed(c_clip) >>> SH);

    always_comb begin
        phase_d     = phase_q;
        dec_go_d    = 1'b0;
        pcm_data_d  = pcm_data_q;
        pcm_valid_d = pcm_valid_q;
        overrun_d   = overrun_q;
        acc         = step;
        for (int k = 0; k < 3; k++) begin
            integ_d[k] = integ_q[k];
            dly_d[k]   = dly_q[k];
        end

        if (sync) begin
            phase_d     = '0;
            pcm_valid_d = 1'b0;
            overrun_d   = 1'b0;
            for (int k = 0; k < 3; k++) begin
                integ_d[k] = '0;
                dly_d[k]   = '0;
            end
        end else begin
            if (sample_valid) begin
                for (int k = 0; k < 3; k++) begin
                    integ_d[k] = integ_q[k] + acc;
                    acc        = integ_d[k];
                end
                phase_d  = phase_q + 1'b1;
                dec_go_d = (phase_q == {LOG2_R{1'b1}});
            end
            if (pcm_valid_q && pcm.pcm_ready) begin
                pcm_valid_d = 1'b0;
            end
            // A load wins over a same-edge handshake and only counts as overrun when the word was not taken.
            if (dec_go_q) begin
                for (int k = 0; k < 3; k++) begin
                    dly_d[k] = comb_s[k];
                end
                pcm_data_d  = word;
                pcm_valid_d = 1'b1;
                if (pcm_valid_q && !pcm.pcm_ready) begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            dec_go_q    <= 1'b0;
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
        end else begin
            phase_q     <= phase_d;
            dec_go_q    <= dec_go_d;
            pcm_data_q  <= pcm_data_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
            for (int k = 0; k < 3; k++) begin
                integ_q[k] <= integ_d[k];
                dly_q[k]   <= dly_d[k];
            end
        end
    end

    assign pcm.pcm_data  = pcm_data_q;
    assign pcm.pcm_valid = pcm_valid_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_pdm_cic_decim.sv
// Directed bench for pdm_cic_decim at default parameters (R = 64, 16-bit words).
// Expected words are hand-derived from the zero-state CIC response; PDM_CIC_SAT_EN selects the full-scale value.
module tb_pdm_cic_decim;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sample_valid = 1'b0;
    logic data = 1'b0;
    logic sync = 1'b0;
    logic overrun;
    int   checks = 0;
    int   failures = 0;

`ifdef PDM_CIC_SAT_EN
    localparam logic [15:0] FS_POS = 16'h7FFF;
`else
    localparam logic [15:0] FS_POS = 16'h8000;
`endif

    pdm_cic_decim_if #(.OUT_BITS(16)) pcm_if ();

    pdm_cic_decim #(.LOG2_R(6), .OUT_BITS(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .data         (data),
        .sync         (sync),
        .pcm          (pcm_if.master),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic pdm_bit(input int mode, input int idx);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return (idx % 2 == 0);
    endfunction

    task automatic strobe(input logic d);
        sample_valid = 1'b1;
        data         = d;
        tick();
        sample_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_sync();
        sync = 1'b1;
        tick();
        sync = 1'b0;
    endtask

    // 64 strobes, one every 4 clocks; v traces pcm_valid 0/1/2 clocks after the last strobe edge.
    task automatic window(input int mode, input logic pulse_ready,
                          output logic [15:0] mid_word, output logic [2:0] v,
                          output logic [15:0] word);
        logic saved;
        mid_word = '0;
        for (int s = 0; s < 63; s++) begin
            strobe(pdm_bit(mode, s));
            if (s == 31) mid_word = pcm_if.pcm_data;
        end
        sample_valid = 1'b1;
        data         = pdm_bit(mode, 63);
        tick();
        sample_valid = 1'b0;
        v[0]  = pcm_if.pcm_valid;
        saved = pcm_if.pcm_ready;
        if (pulse_ready) pcm_if.pcm_ready = 1'b1;
        tick();
        pcm_if.pcm_ready = saved;
        v[1] = pcm_if.pcm_valid;
        word = pcm_if.pcm_data;
        tick();
        v[2] = pcm_if.pcm_valid;
        tick();
        $display("window mode=%0d word=%h valid_trace=%b overrun=%b", mode, word, v, overrun);
    endtask

    initial begin
        logic [15:0] mid, word;
        logic [2:0]  v;
        logic [15:0] ones_exp [0:3];
        logic [15:0] zeros_exp [0:3];
        ones_exp  = '{16'h1658, 16'h6BA8, FS_POS, FS_POS};
        zeros_exp = '{16'hE9A8, 16'h9458, 16'h8000, 16'h8000};

        pcm_if.pcm_ready = 1'b1;
        repeat (3) tick();
        chk("reset_data", pcm_if.pcm_data, 16'h0000);
        chk("reset_valid", 16'(pcm_if.pcm_valid), 16'h0000);
        chk("reset_overrun", 16'(overrun), 16'h0000);
        rst_n = 1'b1;

        // all-ones input, ready tied high
        for (int w = 0; w < 4; w++) begin
            window(1, 1'b0, mid, v, word);
            chk($sformatf("ones_timing_%0d", w), 16'(v), 16'h0002);
            chk($sformatf("ones_word_%0d", w), word, ones_exp[w]);
        end
        chk("ones_overrun", 16'(overrun), 16'h0000);

        // all-zeros input
        do_sync();
        chk("sync_valid", 16'(pcm_if.pcm_valid), 16'h0000);
        for (int w = 0; w < 4; w++) begin
            window(0, 1'b0, mid, v, word);
            chk($sformatf("zeros_word_%0d", w), word, zeros_exp[w]);
        end

        // alternating input: steady-state words are zero
        do_sync();
        for (int w = 0; w < 4; w++) begin
            window(2, 1'b0, mid, v, word);
            if (w >= 2) chk($sformatf("alt_word_%0d", w), word, 16'h0000);
        end

        // overrun: ready low across two windows
        do_sync();
        pcm_if.pcm_ready = 1'b0;
        window(1, 1'b0, mid, v, word);
        chk("hold_trace_1", 16'(v), 16'h0006);
        chk("hold_word_1", word, 16'h1658);
        chk("hold_overrun_1", 16'(overrun), 16'h0000);
        window(1, 1'b0, mid, v, word);
        chk("hold_stable", mid, 16'h1658);
        chk("hold_trace_2", 16'(v), 16'h0007);
        chk("hold_word_2", word, 16'h6BA8);
        chk("hold_overrun_2", 16'(overrun), 16'h0001);
        pcm_if.pcm_ready = 1'b1;
        tick();
        chk("release_valid", 16'(pcm_if.pcm_valid), 16'h0000);
        chk("release_overrun", 16'(overrun), 16'h0001);

        // sync together with a strobe, mid-window, with a word pending and overrun set
        pcm_if.pcm_ready = 1'b0;
        window(1, 1'b0, mid, v, word);
        chk("pre_sync_valid", 16'(pcm_if.pcm_valid), 16'h0001);
        repeat (30) strobe(1'b1);
        sync         = 1'b1;
        sample_valid = 1'b1;
        data         = 1'b1;
        tick();
        sync         = 1'b0;
        sample_valid = 1'b0;
        chk("sync_mid_valid", 16'(pcm_if.pcm_valid), 16'h0000);
        chk("sync_mid_overrun", 16'(overrun), 16'h0000);
        window(1, 1'b0, mid, v, word);
        chk("sync_mid_trace", 16'(v), 16'h0006);
        chk("sync_mid_word", word, 16'h1658);

        // ready pulse coinciding with a new load
        do_sync();
        window(1, 1'b0, mid, v, word);
        window(1, 1'b1, mid, v, word);
        chk("same_cycle_trace", 16'(v), 16'h0007);
        chk("same_cycle_word", word, 16'h6BA8);
        chk("same_cycle_overrun", 16'(overrun), 16'h0000);

        // asynchronous reset between edges, mid-window
        do_sync();
        window(1, 1'b0, mid, v, word);
        window(1, 1'b0, mid, v, word);
        repeat (20) strobe(1'b1);
        chk("pre_rst_overrun", 16'(overrun), 16'h0001);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_data", pcm_if.pcm_data, 16'h0000);
        chk("async_rst_valid", 16'(pcm_if.pcm_valid), 16'h0000);
        chk("async_rst_overrun", 16'(overrun), 16'h0000);
        #2 rst_n = 1'b1;
        pcm_if.pcm_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            window(1, 1'b0, mid, v, word);
            chk($sformatf("post_rst_timing_%0d", w), 16'(v), 16'h0002);
            chk($sformatf("post_rst_word_%0d", w), word, ones_exp[w]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pdm_cic_decim.md
# pdm_cic_decim

Third-order CIC decimator for one PDM channel. It sits directly downstream of `pdm_side_sync` (or `sum_pdm`) and consumes the 1-bit `data`/`sample_valid` stream. It produces signed PCM words at 1/2^LOG2_R of the sample rate, delivered through a valid/ready handshake. It replaces `accum_recv` wherever true PCM output is needed.

## Interface
- `LOG2_R`, 6, log2 of the decimation ratio R (R = 2^LOG2_R); legal range 1..8.
- `OUT_BITS`, 16, output word width; must satisfy OUT_BITS <= 3*LOG2_R+1.
- `clk`  in  1  system clock; the block's only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sample_valid`  in  1  one-cycle strobe qualifying `data`.
- `data`  in  1  PDM bit: 1 maps to +1, 0 maps to -1.
- `sync`  in  1  synchronous restart of the decimation window.
- `pcm_data`  out  OUT_BITS  signed PCM sample.
- `pcm_valid`  out  1  `pcm_data` holds an unconsumed sample.
- `pcm_ready`  in  1  downstream accepts the sample when high together with `pcm_valid`.
- `overrun`  out  1  sticky flag: an unconsumed sample was overwritten.

## Operation
- Internal width W = 3*LOG2_R+2. All integrator and comb arithmetic is two's complement, modulo 2^W; wrap in the integrators is intended.
- Integrators I1..I3 update only on cycles with `sample_valid`: I1 += ±1, I2 += I1(new), I3 += I2(new).
- Phase counter counts `sample_valid` strobes 0..R-1 and wraps. The strobe at phase R-1 closes a window and raises an internal `dec_go` for the next cycle.
- In the `dec_go` cycle, three combs with differential delay 1 run on I3: c = x - x_prev per stage. Each stage's delay register loads that stage's input at the end of the cycle.
- Full result c lies in [-2^(3L), +2^(3L)], where L = LOG2_R. Output word = c arithmetically shifted right by 3L+1-OUT_BITS, taking the low OUT_BITS bits.
- Output register: `pcm_data` and `pcm_valid` load at the end of the `dec_go` cycle. `pcm_valid` clears on the edge ending a cycle with `pcm_valid && pcm_ready`, unless a new load occurs on that same edge.
- While `pcm_valid && !pcm_ready`, `pcm_data` stays stable.
- A load while `pcm_valid && !pcm_ready` overwrites the held word and sets `overrun`. A load in the same cycle as a handshake is not an overrun.
- `overrun` clears only on reset or `sync`.
- `sync` clears the phase counter, I1..I3, the comb delays, `pcm_valid` and `overrun`. It cancels any pending `dec_go`. It has priority over a simultaneous `sample_valid`, which is dropped.
- Zero-state start-up after reset or `sync`: outputs 1 and 2 are transient. From output 3 onward, the output is the exact CIC response.

## Timing
- Reset values: `pcm_data` = 0, `pcm_valid` = 0, `overrun` = 0. Integrators, comb delays and phase are also 0.
- Latency: `sample_valid` at phase R-1 in cycle k gives `dec_go` in cycle k+1 and `pcm_valid` high from cycle k+2.
- Output rate: one word per R strobes. `pcm_ready` may be tied high.
- Back-to-back `sample_valid` on every clock is supported. The minimum spacing between loads is R cycles.
- Asserting `rst_n` low mid-window discards the window immediately. The first window after release starts at phase 0.

## Configuration
- `PDM_CIC_SAT_EN` defined: c is clipped to [-2^(3L), 2^(3L)-1] before the shift. Full-scale positive input then yields the maximum positive word.
- `PDM_CIC_SAT_EN` undefined: no clip. Full-scale positive input (c = +2^(3L)) wraps to the most negative word.

## Test plan
- Defaults, all-ones `data`, strobe every 4 clocks, `pcm_ready`=1 -> outputs 3+ read 0x7FFF with `PDM_CIC_SAT_EN`, 0x8000 without; each load lands exactly 2 clocks after the 64th strobe.
- All-zeros `data` -> outputs 3+ read 0x8000 in both configurations; alternating 1/0 -> outputs 3+ read 0x0000.
- Hold `pcm_ready`=0 across two windows -> the first word is held stable until overwritten, `overrun`=1 after the second load, `pcm_valid` stays 1; asserting `pcm_ready` then drops `pcm_valid` the next clock, and `overrun` remains 1.
- `pcm_ready` pulses in the same cycle as a new load -> `overrun` stays 0 and `pcm_valid` stays 1 with the new word.
- `sync` mid-window, together with a `sample_valid` -> that strobe is ignored, `pcm_valid` and `overrun` read 0 next clock, and the next load occurs 64 strobes after `sync`.
- `rst_n` pulsed low asynchronously between clock edges mid-window -> all outputs read 0 immediately; the transient/steady sequence restarts.
